// File: rtl/instr_encoder_if.sv
// Field-set input, instruction-word output and error/status bundle for instr_encoder.
// master = injection/fetch side, slave = encoder.
interface instr_encoder_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_class;
    logic [2:0]    in_op;
    logic          in_sub;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [31:0]   in_imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [CW-1:0] count;
    logic          err;
    logic          err_clr;

    modport master (
        output in_valid, in_class, in_op, in_sub, in_rd, in_rs1, in_rs2, in_imm,
        output out_ready, err_clr,
        input  in_ready, out_valid, out_instr, count, err
    );

    modport slave (
        input  in_valid, in_class, in_op, in_sub, in_rd, in_rs1, in_rs2, in_imm,
        input  out_ready, err_clr,
        output in_ready, out_valid, out_instr, count, err
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder feeding a DEPTH-entry FIFO toward the fetch path.
// Optional ENC_RANGE_CHECK_EN: drop and flag entries whose immediate does not fit its format.
module instr_encoder #(
    parameter int unsigned DEPTH = 4
) (
    input logic            clk,
    input logic            reset,
    instr_encoder_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [3:0] ClsOp    = 4'd0;
    localparam logic [3:0] ClsOpImm = 4'd1;
    localparam logic [3:0] ClsLoad  = 4'd2;
    localparam logic [3:0] ClsStore = 4'd3;
    localparam logic [3:0] ClsBr    = 4'd4;
    localparam logic [3:0] ClsLui   = 4'd5;
    localparam logic [3:0] ClsAuipc = 4'd6;
    localparam logic [3:0] ClsJal   = 4'd7;
    localparam logic [3:0] ClsJalr  = 4'd8;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   out_instr_q, out_instr_d;
    logic          err_q, err_d;

    logic [31:0] word;
    logic        legal;
    logic        range_ok;
    logic        is_shift;
    logic        accept, push, pop;

    logic [31:0] imm;
    assign imm      = bus.in_imm;
    assign is_shift = (bus.in_op == 3'b001) || (bus.in_op == 3'b101);

    always_comb begin
        word  = 32'h0;
        legal = 1'b1;
        case (bus.in_class)
            ClsOp: word = {1'b0, bus.in_sub & ((bus.in_op == 3'b000) || (bus.in_op == 3'b101)),
                           5'b0, bus.in_rs2, bus.in_rs1, bus.in_op, bus.in_rd, 7'b0110011};
            ClsOpImm: begin
                if (is_shift) begin
                    word = {1'b0, bus.in_sub & (bus.in_op == 3'b101), 5'b0, imm[4:0],
                            bus.in_rs1, bus.in_op, bus.in_rd, 7'b0010011};
                end else begin
                    word = {imm[11:0], bus.in_rs1, bus.in_op, bus.in_rd, 7'b0010011};
                end
            end
            ClsLoad:  word = {imm[11:0], bus.in_rs1, bus.in_op, bus.in_rd, 7'b0000011};
            ClsStore: word = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_op, imm[4:0], 7'b0100011};
            ClsBr:    word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_op, imm[4:1],
                              imm[11], 7'b1100011};
            ClsLui:   word = {imm[31:12], bus.in_rd, 7'b0110111};
            ClsAuipc: word = {imm[31:12], bus.in_rd, 7'b0010111};
            ClsJal:   word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, 7'b1101111};
            ClsJalr:  word = {imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, 7'b1100111};
            default:  legal = 1'b0;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    // Sign-extension checks: the bits above the field's sign bit must all equal it.
    always_comb begin
        range_ok = 1'b1;
        case (bus.in_class)
            ClsOpImm: range_ok = is_shift ? (imm[31:5] == 27'h0)
                                          : (&imm[31:11] || ~|imm[31:11]);
            ClsLoad, ClsStore, ClsJalr: range_ok = &imm[31:11] || ~|imm[31:11];
            ClsBr:    range_ok = (&imm[31:12] || ~|imm[31:12]) && !imm[0];
            ClsJal:   range_ok = (&imm[31:20] || ~|imm[31:20]) && !imm[0];
            ClsLui, ClsAuipc: range_ok = (imm[11:0] == 12'h0);
            default:  range_ok = 1'b1;
        endcase
    end
`else
    assign range_ok = 1'b1;
`endif

    assign bus.in_ready  = (count_q != CW'(DEPTH));
    assign bus.out_valid = (count_q != '0);
    assign bus.out_instr = out_instr_q;
    assign bus.count     = count_q;
    assign bus.err       = err_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign push   = accept && legal && range_ok;
    assign pop    = bus.out_valid && bus.out_ready;

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        out_instr_d = out_instr_q;
        // The new head may be the word being written this very cycle.
        if (count_d != '0) begin
            out_instr_d = (push && (wr_ptr_q == rd_ptr_d)) ? word : mem_q[rd_ptr_d];
        end
        err_d = err_q;
        if (accept && !(legal && range_ok)) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_instr_q <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= word;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_instr_q <= out_instr_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder (DEPTH=4) with hand-computed instruction words.
module tb_instr_encoder;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    instr_encoder_if #(.DEPTH(4)) ifc ();

    instr_encoder #(.DEPTH(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one field set for a single clock; outputs are sampled 1 ns after the edge.
    task automatic send(input logic [3:0] cls, input logic [2:0] op, input logic sub,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
        ifc.in_valid = 1'b1;
        ifc.in_class = cls;
        ifc.in_op    = op;
        ifc.in_sub   = sub;
        ifc.in_rd    = rd;
        ifc.in_rs1   = rs1;
        ifc.in_rs2   = rs2;
        ifc.in_imm   = imm;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp);
        check({tag, "_valid"}, 32'(ifc.out_valid), 32'd1);
        check(tag, ifc.out_instr, exp);
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b0;
    endtask

    initial begin
        ifc.in_valid  = 1'b0;
        ifc.in_class  = 4'd0;
        ifc.in_op     = 3'd0;
        ifc.in_sub    = 1'b0;
        ifc.in_rd     = 5'd0;
        ifc.in_rs1    = 5'd0;
        ifc.in_rs2    = 5'd0;
        ifc.in_imm    = 32'd0;
        ifc.out_ready = 1'b0;
        ifc.err_clr   = 1'b0;
        reset         = 1'b1;
        #12;
        check("rst_count", 32'(ifc.count), 32'd0);
        check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_out_instr", ifc.out_instr, 32'h0);
        check("rst_err", 32'(ifc.err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", 32'(ifc.in_ready), 32'd1);

        // addi x1,x0,5 into empty FIFO
        send(4'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        check("addi_count", 32'(ifc.count), 32'd1);
        pop_check("addi", 32'h00500093);
        check("empty_valid", 32'(ifc.out_valid), 32'd0);
        check("empty_hold", ifc.out_instr, 32'h00500093);

        // add then sub, order preserved
        send(4'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
        send(4'd0, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
        check("addsub_count", 32'(ifc.count), 32'd2);
        pop_check("add", 32'h002081B3);
        pop_check("sub", 32'h402081B3);

        // srai x1,x1,3 -> imm[4:0] in rs2 slot, bit 30 set
        send(4'd1, 3'b101, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3);
        // push and pop together at count 1: the new word becomes head
        ifc.out_ready = 1'b1;
        send(4'd2, 3'b010, 1'b0, 5'd6, 5'd7, 5'd0, 32'hFFFFFFFC);  // lw x6,-4(x7)
        ifc.out_ready = 1'b0;
        check("pushpop_count", 32'(ifc.count), 32'd1);
        pop_check("lw", 32'hFFC3A303);

        // fill with beq, sw, lui, jal
        send(4'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
        send(4'd3, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4);
        send(4'd5, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000);
        send(4'd7, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);
        check("full_count", 32'(ifc.count), 32'd4);
        check("full_in_ready", 32'(ifc.in_ready), 32'd0);
        check("full_head", ifc.out_instr, 32'h00208463);
        // full: pop happens, the simultaneous push is refused
        ifc.out_ready = 1'b1;
        send(4'd8, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'd16);
        ifc.out_ready = 1'b0;
        check("full_pop_count", 32'(ifc.count), 32'd3);
        check("full_pop_in_ready", 32'(ifc.in_ready), 32'd1);
        pop_check("sw", 32'h0020A223);
        pop_check("lui", 32'h123452B7);
        pop_check("jal", 32'h001000EF);
        check("drained_count", 32'(ifc.count), 32'd0);

        // jalr x1,16(x2): funct3 forced to 000
        send(4'd8, 3'b111, 1'b0, 5'd1, 5'd2, 5'd0, 32'd16);
        pop_check("jalr", 32'h010100E7);

        // illegal class
        send(4'd12, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0);
        check("illegal_count", 32'(ifc.count), 32'd0);
        check("illegal_err", 32'(ifc.err), 32'd1);
        ifc.err_clr = 1'b1;
        send(4'd15, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0);
        ifc.err_clr = 1'b0;
        check("err_set_wins", 32'(ifc.err), 32'd1);
        ifc.err_clr = 1'b1;
        @(posedge clk);
        #1;
        ifc.err_clr = 1'b0;
        check("err_cleared", 32'(ifc.err), 32'd0);

        // addi imm=4096
        send(4'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096);
`ifdef ENC_RANGE_CHECK_EN
        check("range_drop_count", 32'(ifc.count), 32'd0);
        check("range_drop_err", 32'(ifc.err), 32'd1);
`else
        check("trunc_err", 32'(ifc.err), 32'd0);
        pop_check("trunc_addi", 32'h00000093);
`endif

        // reset mid-operation discards contents
        send(4'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
        send(4'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
        check("pre_reset_count", 32'(ifc.count), 32'd2);
        reset = 1'b1;
        #1;
        check("mid_reset_count", 32'(ifc.count), 32'd0);
        check("mid_reset_valid", 32'(ifc.out_valid), 32'd0);
        check("mid_reset_instr", ifc.out_instr, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
RV32I instruction encoder. It is the inverse of the core decoder.
- Accepts instruction fields: class, funct3-style op (alu_op_t / branch_op_t / load-store width encodings), sub flag, register indices and immediate.
- Assembles the 32-bit instruction word and buffers it in a small FIFO.
- Sits between the debug/program-injection front end and the instruction fetch path; the fetch side pops words with a valid/ready handshake.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  field set valid
in_ready  out  1  encoder can accept
in_class  in  4  0 OP, 1 OP_IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR; 9-15 illegal
in_op  in  3  funct3 value (alu_op_t, branch_op_t, or width)
in_sub  in  1  sets instr[30] (SUB/SRA/SRAI)
in_rd  in  5  destination register
in_rs1  in  5  source 1
in_rs2  in  5  source 2
in_imm  in  32  immediate, byte offset for branch/jump
out_valid  out  1  out_instr valid
out_ready  in  1  fetch side accepts
out_instr  out  32  encoded word at FIFO head
count  out  $clog2(DEPTH)+1  FIFO occupancy
err  out  1  sticky encode error
err_clr  in  1  clears err

Behaviour:
- Reset (async, reset=1): FIFO empty, count=0, out_valid=0, out_instr=0, err=0. in_ready=1 once reset deasserts.
- Handshakes:
  - Input handshake completes when in_valid && in_ready.
  - in_ready = (count != DEPTH). There is no bypass, so a full FIFO rejects input even if a pop occurs in the same cycle.
  - Output pop occurs when out_valid && out_ready. out_valid = (count != 0).
  - out_instr holds the head entry and is stable while out_valid && !out_ready. When empty, out_instr holds its last value (0 after reset).
- Latency: a word accepted in cycle N appears on out_instr/out_valid in cycle N+1 if the FIFO was empty.
- Simultaneous push and pop when not full and not empty: count unchanged, order preserved.
- Pointers wrap modulo DEPTH.
- Opcodes: OP 0110011, OP_IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
- Field placement: rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20]. Fields unused by the format are zero; funct3 is forced to 000 for JALR.
- R-type (OP): instr[31:25] = {0, in_sub & (op==000 | op==101), 00000}.
- I-type (OP_IMM, LOAD, JALR): instr[31:20] = imm[11:0].
  - Exception, OP_IMM with op 001/101: instr[31:25] = {0, in_sub & (op==101), 00000} and instr[24:20] = imm[4:0].
- S-type: imm[11:5] -> [31:25], imm[4:0] -> [11:7].
- B-type: imm[12] -> [31], imm[10:5] -> [30:25], imm[4:1] -> [11:8], imm[11] -> [7].
- U-type: imm[31:12] -> [31:12].
- J-type: imm[20] -> [31], imm[10:1] -> [30:21], imm[11] -> [20], imm[19:12] -> [19:12].
- Illegal class (9-15): the handshake completes, nothing is pushed, and err is set the next cycle.
- err behaviour: sticky. err_clr clears it; if err_clr and a new error occur in the same cycle, set wins.
- Reset mid-operation discards all FIFO contents immediately.

Optional Feature:
ENC_RANGE_CHECK_EN
- Defined: the encoder range-checks the immediate. An entry that fails is accepted but dropped (not pushed), and err is set. Checks:
  - I/S: signed 12-bit.
  - B: signed 13-bit and imm[0]=0.
  - J: signed 21-bit and imm[0]=0.
  - U: imm[11:0]=0.
  - Shift-immediate: imm[31:5]=0.
- Undefined: immediates are silently truncated per the field placement above; only the illegal class sets err.

Test Plan:
- addi x1,x0,5 (class 1, op 000, rd 1, imm 5) into an empty FIFO -> out_valid next cycle, out_instr=0x00500093, count=1.
- add x3,x1,x2 then the same with in_sub=1 -> 0x002081B3 then 0x402081B3, in order.
- beq x1,x2,+8 -> 0x00208463; sw x2,4(x1) -> 0x0020A223; lui x5,imm 0x12345000 -> 0x123452B7; jal x1,+2048 -> 0x001000EF.
- Fill to DEPTH=4 with out_ready=0 -> in_ready=0, count=4. Assert in_valid and out_ready together -> one pop, no push. Next cycle in_ready=1. Words drain in FIFO order.
- in_class=12 -> nothing pushed, count unchanged, err=1 next cycle. err_clr pulsed together with another illegal entry -> err stays 1. err_clr alone -> err=0.
- With ENC_RANGE_CHECK_EN: addi imm=4096 -> dropped, err=1. Without it: out_instr=0x00000093.
